// File: rtl/cordic_cmd_sequencer.sv
// Command sequencer for the CORDIC calculator. Commands are buffered in a
// small FIFO and issued one at a time. Each result is captured on calc_done
// and presented on a valid/ready response port. Timeouts and the DEFAULT
// opcode are reported as errors.
module cordic_cmd_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [WIDTH-1:0]       cmd_x,
  input  logic [WIDTH-1:0]       cmd_y,
  input  logic [WIDTH-1:0]       cmd_z,
  output logic                   calc_enable,
  output logic [3:0]             calc_operation,
  output logic [WIDTH-1:0]       calc_x,
  output logic [WIDTH-1:0]       calc_y,
  output logic [WIDTH-1:0]       calc_z,
  input  logic [WIDTH-1:0]       calc_result,
  input  logic                   calc_done,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic [3:0]             rsp_op,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] OP_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t r_state;

  logic [3:0]       r_memOp [DEPTH];
  logic [WIDTH-1:0] r_memX  [DEPTH];
  logic [WIDTH-1:0] r_memY  [DEPTH];
  logic [WIDTH-1:0] r_memZ  [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [TW-1:0]    r_waitCnt;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_countNext;
  logic [3:0]       w_headOp;
  logic [WIDTH-1:0] w_headX;
  logic [WIDTH-1:0] w_headY;
  logic [WIDTH-1:0] w_headZ;

  assign w_push   = cmd_valid && cmd_ready;
  assign w_pop    = (r_state == IDLE) && (fifo_count != '0);
  assign w_headOp = r_memOp[r_rdPtr];
  assign w_headX  = r_memX[r_rdPtr];
  assign w_headY  = r_memY[r_rdPtr];
  assign w_headZ  = r_memZ[r_rdPtr];

  // Occupancy after this edge; a simultaneous push and pop cancel out
  always_comb begin
    w_countNext = fifo_count;
    if (w_push && !w_pop) begin
      w_countNext = fifo_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_countNext = fifo_count - CW'(1);
    end
  end

  // FIFO storage; stale entries are harmless because the pointers gate them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memOp[r_wrPtr] <= cmd_op;
      r_memX[r_wrPtr]  <= cmd_x;
      r_memY[r_wrPtr]  <= cmd_y;
      r_memZ[r_wrPtr]  <= cmd_z;
    end
  end

  // FIFO pointers, occupancy and registered ready (no input-to-ready path)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      fifo_count <= '0;
      cmd_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      fifo_count <= w_countNext;
      cmd_ready  <= (w_countNext < CW'(DEPTH));
    end
  end

  // Issue/wait/capture sequencing with all calculator and response outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_waitCnt      <= '0;
      calc_enable    <= 1'b0;
      calc_operation <= OP_DEFAULT;
      calc_x         <= '0;
      calc_y         <= '0;
      calc_z         <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_op         <= OP_DEFAULT;
      rsp_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      calc_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          busy <= (w_countNext != '0);
          if (w_pop) begin
            busy <= 1'b1;
            if (w_headOp == OP_DEFAULT) begin
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_op     <= OP_DEFAULT;
              r_state    <= HOLD;
            end else begin
              calc_operation <= w_headOp;
              calc_x         <= w_headX;
              calc_y         <= w_headY;
              calc_z         <= w_headZ;
              calc_enable    <= 1'b1;
              r_state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          busy      <= 1'b1;
          r_waitCnt <= '0;
          r_state   <= WAIT;
        end
        WAIT: begin
          busy <= 1'b1;
          if ((r_waitCnt != '0) && calc_done) begin
            rsp_valid  <= 1'b1;
            rsp_result <= calc_result;
            rsp_err    <= 1'b0;
            rsp_op     <= calc_operation;
            r_state    <= HOLD;
          end else if (r_waitCnt == TW'(TIMEOUT - 1)) begin
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_op     <= calc_operation;
            r_state    <= HOLD;
          end else begin
            r_waitCnt <= r_waitCnt + TW'(1);
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= (w_countNext != '0);
            r_state   <= IDLE;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_cmd_sequencer.sv
// Self-checking bench for cordic_cmd_sequencer. A behavioural calculator model
// answers each calc_enable, and a scoreboard queue holds the expected responses.
module tb_cordic_cmd_sequencer;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  localparam logic [3:0] OP_SIN  = 4'h0;
  localparam logic [3:0] OP_COS  = 4'h1;
  localparam logic [3:0] OP_SINH = 4'h4;
  localparam logic [3:0] OP_COSH = 4'h5;
  localparam logic [3:0] OP_MULT = 4'h8;
  localparam logic [3:0] OP_DIV  = 4'h9;
  localparam logic [3:0] OP_ILL  = 4'hF;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] result;
    logic        err;
  } cmd_t;

  logic                   clk;
  logic                   rst;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [3:0]             cmd_op;
  logic [WIDTH-1:0]       cmd_x;
  logic [WIDTH-1:0]       cmd_y;
  logic [WIDTH-1:0]       cmd_z;
  logic                   calc_enable;
  logic [3:0]             calc_operation;
  logic [WIDTH-1:0]       calc_x;
  logic [WIDTH-1:0]       calc_y;
  logic [WIDTH-1:0]       calc_z;
  logic [WIDTH-1:0]       calc_result;
  logic                   calc_done;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_result;
  logic [3:0]             rsp_op;
  logic                   rsp_err;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int   compareCount;
  int   mismatchCount;
  cmd_t rspQ[$];
  cmd_t issueQ[$];

  int          calcMode;
  int          calcLatency;
  int          tSince;
  bit          modelActive;
  int          enableCount;
  time         enableTime;
  time         pushTime;
  logic [31:0] latX;
  logic [31:0] latZ;
  cmd_t        modelExp;

  bit          rspPrev;
  int          rspSeen;
  time         lastRspTime;
  logic [31:0] snapResult;
  logic [3:0]  snapOp;
  logic        snapErr;
  cmd_t        monExp;

  cordic_cmd_sequencer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_x(cmd_x),
    .cmd_y(cmd_y),
    .cmd_z(cmd_z),
    .calc_enable(calc_enable),
    .calc_operation(calc_operation),
    .calc_x(calc_x),
    .calc_y(calc_y),
    .calc_z(calc_z),
    .calc_result(calc_result),
    .calc_done(calc_done),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_op(rsp_op),
    .rsp_err(rsp_err),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Stand-in for the calculator arithmetic; MULT is a real Q16.16 product
  function automatic logic [31:0] fakeCalc(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] z);
    logic signed [63:0] prod;
    if (op == OP_MULT) begin
      prod = 64'($signed(x)) * 64'($signed(z));
      return prod[47:16];
    end else if (op == OP_SIN && z == 32'h0000C90F) begin
      return 32'h0000B505;
    end
    return x ^ {y[30:0], 1'b0} ^ z ^ {28'd0, op};
  endfunction

  // Calculator model: mode 0 done after calcLatency, mode 1 never done, mode 2 stale-done pattern
  always @(negedge clk) begin
    if (!rst) begin
      modelActive = 1'b0;
      calc_done   = 1'b0;
    end else begin
      if (calc_enable) begin
        enableCount++;
        enableTime  = $time;
        tSince      = 0;
        modelActive = 1'b1;
        latX        = calc_x;
        latZ        = calc_z;
        calc_result = fakeCalc(calc_operation, calc_x, calc_y, calc_z);
        if (issueQ.size() == 0) begin
          checkOutput("issue_unexpected", 32'd1, 32'd0);
        end else begin
          modelExp = issueQ.pop_front();
          checkOutput("issue_op", 32'(calc_operation), 32'(modelExp.op));
          checkOutput("issue_x", calc_x, modelExp.x);
          checkOutput("issue_z", calc_z, modelExp.z);
        end
      end else if (modelActive) begin
        tSince++;
        checkOutput("hold_x", calc_x, latX);
        checkOutput("hold_z", calc_z, latZ);
      end
      if (modelActive) begin
        case (calcMode)
          0:       calc_done = (tSince >= calcLatency);
          1:       calc_done = 1'b0;
          default: calc_done = (tSince <= 1) || (tSince >= 9);
        endcase
      end
    end
  end

  // Response monitor: compare each new response to the scoreboard and check stability while held
  always @(negedge clk) begin
    if (!rst) begin
      rspPrev = 1'b0;
    end else begin
      if (rsp_valid && !rspPrev) begin
        rspSeen++;
        lastRspTime = $time;
        snapResult  = rsp_result;
        snapOp      = rsp_op;
        snapErr     = rsp_err;
        if (rspQ.size() == 0) begin
          checkOutput("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          monExp = rspQ.pop_front();
          checkOutput("rsp_result", rsp_result, monExp.result);
          checkOutput("rsp_op", 32'(rsp_op), 32'(monExp.op));
          checkOutput("rsp_err", 32'(rsp_err), 32'(monExp.err));
        end
      end else if (rsp_valid) begin
        checkOutput("rsp_stable_result", rsp_result, snapResult);
        checkOutput("rsp_stable_op", 32'(rsp_op), 32'(snapOp));
        checkOutput("rsp_stable_err", 32'(rsp_err), 32'(snapErr));
      end
      rspPrev = rsp_valid;
    end
  end

  // Push one command once the FIFO has room and record its expected response
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] z);
    cmd_t e;
    int   guard = 0;
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_wait", 32'd0, 32'd1);
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_x     = x;
      cmd_y     = y;
      cmd_z     = z;
      e.op = op;
      e.x  = x;
      e.y  = y;
      e.z  = z;
      if (op == OP_ILL) begin
        e.result = 32'd0;
        e.err    = 1'b1;
      end else if (calcMode == 1) begin
        e.result = 32'd0;
        e.err    = 1'b1;
      end else begin
        e.result = fakeCalc(op, x, y, z);
        e.err    = 1'b0;
      end
      rspQ.push_back(e);
      if (op != OP_ILL) begin
        issueQ.push_back(e);
      end
      pushTime = $time;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic waitRsp(input int target, input int maxCycles);
    int n = 0;
    while (rspSeen < target && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (rspSeen < target) begin
      checkOutput("rsp_wait", 32'(rspSeen), 32'(target));
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy || rsp_valid) begin
      checkOutput("idle_wait", 32'(busy), 32'd0);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_calc_enable", 32'(calc_enable), 32'd0);
    checkOutput("rst_calc_op", 32'(calc_operation), 32'hF);
    checkOutput("rst_calc_x", calc_x, 32'd0);
    checkOutput("rst_calc_y", calc_y, 32'd0);
    checkOutput("rst_calc_z", calc_z, 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_result", rsp_result, 32'd0);
    checkOutput("rst_rsp_op", 32'(rsp_op), 32'hF);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run still active, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    int baseEn;
    int baseRsp;
    compareCount  = 0;
    mismatchCount = 0;
    rst         = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 4'h0;
    cmd_x       = '0;
    cmd_y       = '0;
    cmd_z       = '0;
    calc_result = '0;
    calc_done   = 1'b0;
    rsp_ready   = 1'b1;
    calcMode    = 0;
    calcLatency = 5;
    enableCount = 0;
    rspSeen     = 0;
    repeat (3) @(negedge clk);
    checkResetValues();
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] SIN with 20-cycle calculator latency");
    calcLatency = 20;
    baseEn  = enableCount;
    baseRsp = rspSeen;
    applyStimulus(OP_SIN, 32'd0, 32'd0, 32'h0000C90F);
    waitRsp(baseRsp + 1, 100);
    checkOutput("sin_enable_pulses", 32'(enableCount - baseEn), 32'd1);
    checkOutput("sin_latency", 32'((lastRspTime - enableTime) / 10), 32'd21);

    $display("[TB] fill with backpressure");
    waitIdle();
    rsp_ready   = 1'b0;
    calcLatency = 5;
    baseRsp     = rspSeen;
    applyStimulus(OP_MULT, 32'h00018000, 32'd0, 32'h00020000);
    applyStimulus(OP_DIV,  32'h00030000, 32'd0, 32'h00010000);
    applyStimulus(OP_SINH, 32'd0, 32'd0, 32'h00008000);
    applyStimulus(OP_COSH, 32'd0, 32'd0, 32'h00004000);
    applyStimulus(OP_COS,  32'd0, 32'd0, 32'h00002000);
    checkOutput("fill_count", 32'(fifo_count), 32'd4);
    checkOutput("fill_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("fill_held_valid", 32'(rsp_valid), 32'd1);
    checkOutput("fill_count_held", 32'(fifo_count), 32'd4);
    rsp_ready = 1'b1;
    waitRsp(baseRsp + 5, 300);

    $display("[TB] timeout then normal command");
    waitIdle();
    calcMode = 1;
    baseRsp  = rspSeen;
    applyStimulus(OP_COS, 32'h1, 32'h2, 32'h3);
    waitRsp(baseRsp + 1, TIMEOUT + 40);
    checkOutput("timeout_latency", 32'((lastRspTime - enableTime) / 10), 32'(TIMEOUT + 1));
    waitIdle();
    calcMode    = 0;
    calcLatency = 3;
    applyStimulus(OP_SINH, 32'h00011111, 32'h00022222, 32'h00033333);
    waitRsp(baseRsp + 2, 100);
    checkOutput("after_timeout_latency", 32'((lastRspTime - enableTime) / 10), 32'd4);

    $display("[TB] illegal opcode");
    waitIdle();
    baseEn  = enableCount;
    baseRsp = rspSeen;
    applyStimulus(OP_ILL, 32'h5, 32'h6, 32'h7);
    waitRsp(baseRsp + 1, 20);
    checkOutput("ill_enable_pulses", 32'(enableCount - baseEn), 32'd0);
    checkOutput("ill_within_2", 32'(((lastRspTime - pushTime) / 10) <= 2), 32'd1);

    $display("[TB] stale done guard");
    waitIdle();
    calcMode  = 2;
    calc_done = 1'b1;
    @(negedge clk);
    baseRsp = rspSeen;
    applyStimulus(OP_COSH, 32'h00001234, 32'd0, 32'h00005678);
    waitRsp(baseRsp + 1, 60);
    checkOutput("stale_latency", 32'((lastRspTime - enableTime) / 10), 32'd10);

    $display("[TB] reset during WAIT with two queued");
    waitIdle();
    calcMode    = 0;
    calcLatency = 40;
    baseEn      = enableCount;
    applyStimulus(OP_SIN, 32'd0, 32'd0, 32'h00000100);
    applyStimulus(OP_COS, 32'd0, 32'd0, 32'h00000200);
    applyStimulus(OP_DIV, 32'h00040000, 32'd0, 32'h00020000);
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_count", 32'(fifo_count), 32'd2);
    checkOutput("pre_reset_enables", 32'(enableCount - baseEn), 32'd1);
    rst = 1'b0;
    #1;
    checkResetValues();
    rspQ.delete();
    issueQ.delete();
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    baseEn  = enableCount;
    baseRsp = rspSeen;
    repeat (20) @(negedge clk);
    checkOutput("post_reset_no_rsp", 32'(rspSeen - baseRsp), 32'd0);
    checkOutput("post_reset_no_enable", 32'(enableCount - baseEn), 32'd0);
    checkOutput("post_reset_count", 32'(fifo_count), 32'd0);
    calcLatency = 4;
    applyStimulus(OP_MULT, 32'h00020000, 32'd0, 32'h00030000);
    waitRsp(baseRsp + 1, 100);
    checkOutput("post_reset_latency", 32'((lastRspTime - enableTime) / 10), 32'd5);

    waitIdle();
    checkOutput("end_rsp_queue_empty", 32'(rspQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
